// File: rtl/i2c_req_sched_if.sv
// Scheduler-to-I2C-core bus: transaction setup, write-byte stream, read-byte return and status.
`timescale 1ns/1ps
interface i2c_req_sched_if;
  logic        i2c_ready;
  logic [7:0]  tx_apb_addr;
  logic [7:0]  tx_apb_data_cnt;
  logic [15:0] tx_ctrl;
  logic [7:0]  tx_apb_data;
  logic        tx_data_en;
  logic        core_byte_req;
  logic [7:0]  rx_apb_data;
  logic        core_rx_valid;
  logic [7:0]  status;

  modport master (
    input  i2c_ready, core_byte_req, rx_apb_data, core_rx_valid, status,
    output tx_apb_addr, tx_apb_data_cnt, tx_ctrl, tx_apb_data, tx_data_en
  );

  modport slave (
    output i2c_ready, core_byte_req, rx_apb_data, core_rx_valid, status,
    input  tx_apb_addr, tx_apb_data_cnt, tx_ctrl, tx_apb_data, tx_data_en
  );
endinterface

// File: rtl/i2c_req_sched.sv
// Grants one of NUM_REQ requesters the I2C core and runs one full transaction per grant.
// Define I2C_SCHED_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
`timescale 1ns/1ps
module i2c_req_sched #(
  parameter int          NUM_REQ   = 4,
  parameter logic [19:0] TO_CYCLES = 20'hFFFFF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*7-1:0] req_addr,
  input  logic [NUM_REQ-1:0]   req_rw,
  input  logic [NUM_REQ*8-1:0] req_cnt,
  input  logic [NUM_REQ*8-1:0] req_wdata,
  output logic [NUM_REQ-1:0]   req_wpop,
  output logic [7:0]           req_rdata,
  output logic [NUM_REQ-1:0]   req_rvalid,
  output logic [NUM_REQ-1:0]   req_done,
  output logic [1:0]           req_err,
  output logic [NUM_REQ-1:0]   gnt,
  i2c_req_sched_if.master      core
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [NUM_REQ-1:0] GNT_ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARB    = 3'd1,
    LOAD   = 3'd2,
    START  = 3'd3,
    XFER   = 3'd4,
    FINISH = 3'd5
  } state_t;

  state_t             state_r, state_nxt_s;
  logic [IDX_W-1:0]   gidx_r, win_idx_s, cand_s;
  logic               win_found_s;
  logic               rw_r;
  logic [7:0]         rem_r;
  logic [19:0]        to_cnt_r;
  logic [6:0]         sel_addr_s;
  logic               sel_rw_s;
  logic [7:0]         sel_cnt_s, sel_wdata_s;
  logic               fin_nack_s, fin_to_s, wr_evt_s, rd_evt_s;
  logic               status_unused_s;
`ifndef I2C_SCHED_FIXED_PRIO_EN
  logic [IDX_W-1:0]   ptr_r;
`endif

  assign status_unused_s = ^core.status[7:2];

  // Pick the winning requester for this ARB cycle.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = {IDX_W{1'b0}};
    cand_s      = {IDX_W{1'b0}};
`ifdef I2C_SCHED_FIXED_PRIO_EN
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_s = IDX_W'(k);
`else
    // Search begins one past the last winner so every requester gets a turn.
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand_s = IDX_W'((int'(ptr_r) + k) % NUM_REQ);
`endif
      if (req_valid[cand_s] && !win_found_s) begin
        win_found_s = 1'b1;
        win_idx_s   = cand_s;
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Fields of the granted requester.
  always_comb begin
    sel_addr_s  = 7'd0;
    sel_rw_s    = 1'b0;
    sel_cnt_s   = 8'd0;
    sel_wdata_s = 8'd0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gidx_r == IDX_W'(k)) begin
        sel_addr_s  = req_addr[k*7 +: 7];
        sel_rw_s    = req_rw[k];
        sel_cnt_s   = req_cnt[k*8 +: 8];
        sel_wdata_s = req_wdata[k*8 +: 8];
      end else begin
        sel_addr_s  = sel_addr_s;
      end
    end
  end

  // Next state, close-out reason and byte events.
  always_comb begin
    state_nxt_s = state_r;
    fin_nack_s  = 1'b0;
    fin_to_s    = 1'b0;
    wr_evt_s    = 1'b0;
    rd_evt_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if ((|req_valid) && core.i2c_ready) state_nxt_s = ARB;
        else                                state_nxt_s = IDLE;
      end
      ARB: begin
        if (win_found_s) state_nxt_s = LOAD;
        else             state_nxt_s = IDLE;
      end
      LOAD:  state_nxt_s = START;
      START: state_nxt_s = XFER;
      XFER: begin
        // Only the event matching the transfer direction is served.
        wr_evt_s = core.core_byte_req && !rw_r && (rem_r != 8'd0);
        rd_evt_s = core.core_rx_valid && rw_r && (rem_r != 8'd0);
        if (core.status[0] || core.status[1]) begin
          state_nxt_s = FINISH;
          fin_nack_s  = core.status[0];
        end else if (to_cnt_r == TO_CYCLES - 20'd1) begin
          state_nxt_s = FINISH;
          fin_to_s    = 1'b1;
        end else begin
          state_nxt_s = XFER;
        end
      end
      FINISH:  state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_nxt_s;
  end

  // Registered outputs, grant, counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt                  <= {NUM_REQ{1'b0}};
      gidx_r               <= {IDX_W{1'b0}};
`ifndef I2C_SCHED_FIXED_PRIO_EN
      ptr_r                <= {IDX_W{1'b0}};
`endif
      req_wpop             <= {NUM_REQ{1'b0}};
      req_rvalid           <= {NUM_REQ{1'b0}};
      req_done             <= {NUM_REQ{1'b0}};
      req_rdata            <= 8'd0;
      req_err              <= 2'b00;
      rw_r                 <= 1'b0;
      rem_r                <= 8'd0;
      to_cnt_r             <= 20'd0;
      core.tx_apb_addr     <= 8'd0;
      core.tx_apb_data_cnt <= 8'd0;
      core.tx_ctrl         <= 16'd0;
      core.tx_apb_data     <= 8'd0;
      core.tx_data_en      <= 1'b0;
    end else begin
      req_wpop        <= {NUM_REQ{1'b0}};
      req_rvalid      <= {NUM_REQ{1'b0}};
      req_done        <= {NUM_REQ{1'b0}};
      core.tx_data_en <= 1'b0;
      case (state_r)
        ARB: begin
          if (win_found_s) begin
            gnt    <= GNT_ONE << win_idx_s;
            gidx_r <= win_idx_s;
`ifndef I2C_SCHED_FIXED_PRIO_EN
            ptr_r  <= win_idx_s;
`endif
          end else begin
            gnt    <= {NUM_REQ{1'b0}};
          end
        end
        LOAD: begin
          core.tx_apb_addr     <= {sel_addr_s, sel_rw_s};
          core.tx_apb_data_cnt <= sel_cnt_s;
          core.tx_ctrl         <= {14'd0, sel_rw_s, 1'b1};
          rw_r                 <= sel_rw_s;
          rem_r                <= sel_cnt_s;
          to_cnt_r             <= 20'd0;
        end
        START: begin
          core.tx_ctrl[0] <= 1'b0;
          to_cnt_r        <= to_cnt_r + 20'd1;
        end
        XFER: begin
          to_cnt_r <= to_cnt_r + 20'd1;
          if (wr_evt_s) begin
            core.tx_apb_data <= sel_wdata_s;
            core.tx_data_en  <= 1'b1;
            req_wpop         <= gnt;
            rem_r            <= rem_r - 8'd1;
          end
          if (rd_evt_s) begin
            req_rdata  <= core.rx_apb_data;
            req_rvalid <= gnt;
            rem_r      <= rem_r - 8'd1;
          end
          if (state_nxt_s == FINISH) begin
            req_done     <= gnt;
            req_err      <= {fin_to_s, fin_nack_s};
            gnt          <= {NUM_REQ{1'b0}};
            core.tx_ctrl <= 16'd0;
          end
        end
        FINISH:  req_err <= 2'b00;
        default: req_err <= req_err;
      endcase
    end
  end
endmodule

// File: tb/tb_i2c_req_sched.sv
// Scoreboard bench for i2c_req_sched: expected core/requester events are queued as stimulus is driven.
`timescale 1ns/1ps
module tb_i2c_req_sched;
  localparam int NR = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [NR-1:0] req_valid, req_rw, req_wpop, req_rvalid, req_done, gnt;
  logic [NR*7-1:0] req_addr;
  logic [NR*8-1:0] req_cnt, req_wdata;
  logic [7:0]    req_rdata;
  logic [1:0]    req_err;

  i2c_req_sched_if bus();

  i2c_req_sched #(.NUM_REQ(NR), .TO_CYCLES(20'd100)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_rw(req_rw),
    .req_cnt(req_cnt), .req_wdata(req_wdata), .req_wpop(req_wpop),
    .req_rdata(req_rdata), .req_rvalid(req_rvalid), .req_done(req_done),
    .req_err(req_err), .gnt(gnt), .core(bus)
  );

  always #5 clk = ~clk;

  int  n_total = 0, n_bad = 0, cyc = 0, start_cyc = 0, done_cyc = 0;
  bit  start_seen = 1'b0, done_seen = 1'b0;
  logic [63:0] exp_start_q[$], exp_wr_q[$], exp_rd_q[$], exp_done_q[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] exp_start(input logic [3:0] oh, input logic [6:0] a,
                                            input logic rw, input logic [7:0] cnt);
    return {28'd0, oh, a, rw, cnt, 14'd0, rw, 1'b1};
  endfunction

  // Advance one clock, then sample outputs and match them against the scoreboard.
  task automatic tick();
    logic [63:0] e;
    @(posedge clk);
    #1;
    cyc++;
    if (bus.tx_ctrl[0]) begin
      start_seen = 1'b1;
      start_cyc  = cyc;
      check_eq("start_pending", 64'(exp_start_q.size() > 0), 64'd1);
      if (exp_start_q.size() > 0) begin
        e = exp_start_q.pop_front();
        check_eq("start", {28'd0, gnt, bus.tx_apb_addr, bus.tx_apb_data_cnt, bus.tx_ctrl}, e);
      end
    end
    if (bus.tx_data_en || (|req_wpop)) begin
      check_eq("wr_pending", 64'(exp_wr_q.size() > 0), 64'd1);
      if (exp_wr_q.size() > 0) begin
        e = exp_wr_q.pop_front();
        check_eq("wr_byte", {51'd0, bus.tx_data_en, req_wpop, bus.tx_apb_data}, e);
      end
    end
    if (|req_rvalid) begin
      check_eq("rd_pending", 64'(exp_rd_q.size() > 0), 64'd1);
      if (exp_rd_q.size() > 0) begin
        e = exp_rd_q.pop_front();
        check_eq("rd_byte", {52'd0, req_rvalid, req_rdata}, e);
      end
    end
    if (|req_done) begin
      done_seen = 1'b1;
      done_cyc  = cyc;
      check_eq("done_pending", 64'(exp_done_q.size() > 0), 64'd1);
      if (exp_done_q.size() > 0) begin
        e = exp_done_q.pop_front();
        check_eq("done", {58'd0, req_done, req_err}, e);
      end
    end
  endtask

  task automatic wait_start(input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      if (start_seen) break;
      tick();
    end
    check_eq({tag, "_start_seen"}, 64'(start_seen), 64'd1);
  endtask

  task automatic wait_done(input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      if (done_seen) break;
      tick();
    end
    check_eq({tag, "_done_seen"}, 64'(done_seen), 64'd1);
  endtask

  task automatic check_outputs_idle(input string tag);
    check_eq({tag, "_req_out"}, {38'd0, req_wpop, req_rdata, req_rvalid, req_done, req_err, gnt}, 64'd0);
    check_eq({tag, "_core_out"}, {23'd0, bus.tx_apb_addr, bus.tx_apb_data_cnt, bus.tx_ctrl,
                                  bus.tx_apb_data, bus.tx_data_en}, 64'd0);
  endtask

  task automatic set_req(input int k, input logic [6:0] a, input logic rw,
                         input logic [7:0] cnt, input logic [7:0] wd);
    req_addr[k*7 +: 7]  = a;
    req_rw[k]           = rw;
    req_cnt[k*8 +: 8]   = cnt;
    req_wdata[k*8 +: 8] = wd;
  endtask

  // Close the current transaction through status and drop the requester in its done cycle.
  task automatic finish_xfer(input int k, input logic [7:0] st, input logic [1:0] err, input string tag);
    exp_done_q.push_back({58'd0, 4'(1 << k), err});
    bus.status = st;
    done_seen  = 1'b0;
    wait_done(6, tag);
    bus.status   = 8'h00;
    req_valid[k] = 1'b0;
    check_eq({tag, "_gnt_clr"}, 64'(gnt), 64'd0);
    start_seen = 1'b0;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    repeat (3) tick();
    check_outputs_idle("reset");
    rst = 1'b0;
  endtask

  logic [7:0] wb [3];
  int order [4];
  int req_cyc, w;

  initial begin
    wb = '{8'hA1, 8'hB2, 8'hC3};
`ifdef I2C_SCHED_FIXED_PRIO_EN
    order = '{0, 1, 2, 3};
`else
    order = '{1, 2, 3, 0};
`endif
    rst = 1'b1;
    req_valid = '0; req_rw = '0; req_addr = '0; req_cnt = '0; req_wdata = '0;
    bus.i2c_ready = 1'b0; bus.core_byte_req = 1'b0; bus.core_rx_valid = 1'b0;
    bus.rx_apb_data = 8'h00; bus.status = 8'h00;
    reset_dut();

    // Single write: held off while core busy, then three bytes plus one excess request.
    set_req(0, 7'h50, 1'b0, 8'd3, wb[0]);
    req_valid  = 4'b0001;
    start_seen = 1'b0;
    repeat (4) tick();
    check_eq("ready_block", 64'(start_seen), 64'd0);
    exp_start_q.push_back(exp_start(4'b0001, 7'h50, 1'b0, 8'd3));
    bus.i2c_ready = 1'b1;
    req_cyc = cyc;
    wait_start(10, "wr");
    check_eq("wr_latency", 64'(start_cyc - req_cyc), 64'd3);
    tick();
    for (int i = 0; i < 3; i++) begin
      exp_wr_q.push_back({51'd0, 1'b1, 4'b0001, wb[i]});
      bus.core_byte_req = 1'b1;
      tick();
      bus.core_byte_req = 1'b0;
      if (i < 2) req_wdata[7:0] = wb[i+1];
      tick();
    end
    bus.core_byte_req = 1'b1;
    tick();
    bus.core_byte_req = 1'b0;
    finish_xfer(0, 8'h02, 2'b00, "wr");
    repeat (2) tick();

    // Read on requester 2, second byte arrives with a mismatched byte request.
    set_req(2, 7'h1D, 1'b1, 8'd2, 8'h00);
    req_valid = 4'b0100;
    exp_start_q.push_back(exp_start(4'b0100, 7'h1D, 1'b1, 8'd2));
    wait_start(10, "rd");
    tick();
    for (int i = 0; i < 2; i++) begin
      bus.rx_apb_data = (i == 0) ? 8'h5A : 8'h3C;
      exp_rd_q.push_back({52'd0, 4'b0100, bus.rx_apb_data});
      bus.core_rx_valid = 1'b1;
      bus.core_byte_req = (i == 1);
      tick();
      bus.core_rx_valid = 1'b0;
      bus.core_byte_req = 1'b0;
      tick();
    end
    bus.rx_apb_data = 8'hFF;
    bus.core_rx_valid = 1'b1;
    tick();
    bus.core_rx_valid = 1'b0;
    finish_xfer(2, 8'h02, 2'b00, "rd");

    // Arbitration order with all four requesters held valid, address-only probes.
    reset_dut();
    for (int k = 0; k < NR; k++) set_req(k, 7'(7'h10 + k), 1'b0, 8'd0, 8'h00);
    req_valid = 4'b1111;
    for (int j = 0; j < NR; j++) begin
      w = order[j];
      exp_start_q.push_back(exp_start(4'(1 << w), 7'(7'h10 + w), 1'b0, 8'd0));
      start_seen = 1'b0;
      wait_start(12, "arb");
      tick();
      bus.core_byte_req = (j == 0);
      tick();
      bus.core_byte_req = 1'b0;
      finish_xfer(w, 8'h02, 2'b00, "arb");
    end

    // NACK alone, then NACK together with done.
    set_req(1, 7'h22, 1'b0, 8'd2, 8'h77);
    req_valid = 4'b0010;
    exp_start_q.push_back(exp_start(4'b0010, 7'h22, 1'b0, 8'd2));
    wait_start(10, "nack");
    tick();
    finish_xfer(1, 8'h01, 2'b01, "nack");
    set_req(3, 7'h33, 1'b0, 8'd1, 8'h88);
    req_valid = 4'b1000;
    exp_start_q.push_back(exp_start(4'b1000, 7'h33, 1'b0, 8'd1));
    wait_start(10, "nack_done");
    tick();
    finish_xfer(3, 8'h03, 2'b01, "nack_done");

    // Timeout with a silent core.
    set_req(3, 7'h0F, 1'b1, 8'd1, 8'h00);
    req_valid = 4'b1000;
    exp_start_q.push_back(exp_start(4'b1000, 7'h0F, 1'b1, 8'd1));
    wait_start(10, "to");
    exp_done_q.push_back({58'd0, 4'b1000, 2'b10});
    done_seen = 1'b0;
    wait_done(150, "to");
    req_valid = 4'b0000;
    check_eq("to_latency", 64'(done_cyc - start_cyc), 64'd100);

    // Reset after the first of three write bytes, then a fresh request.
    tick();
    set_req(0, 7'h50, 1'b0, 8'd3, wb[0]);
    req_valid  = 4'b0001;
    start_seen = 1'b0;
    exp_start_q.push_back(exp_start(4'b0001, 7'h50, 1'b0, 8'd3));
    wait_start(10, "rst_mid");
    tick();
    exp_wr_q.push_back({51'd0, 1'b1, 4'b0001, wb[0]});
    bus.core_byte_req = 1'b1;
    tick();
    bus.core_byte_req = 1'b0;
    rst = 1'b1;
    req_valid = 4'b0000;
    done_seen = 1'b0;
    tick();
    check_outputs_idle("rst_mid");
    rst = 1'b0;
    repeat (5) tick();
    check_eq("rst_no_done", 64'(done_seen), 64'd0);
    set_req(1, 7'h2A, 1'b0, 8'd0, 8'h00);
    req_valid  = 4'b0010;
    start_seen = 1'b0;
    exp_start_q.push_back(exp_start(4'b0010, 7'h2A, 1'b0, 8'd0));
    wait_start(10, "after_rst");
    tick();
    finish_xfer(1, 8'h02, 2'b00, "after_rst");
    repeat (3) tick();

    check_eq("sb_left", 64'(exp_start_q.size() + exp_wr_q.size() + exp_rd_q.size() + exp_done_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
